// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bundle: instruction-memory handshake, decode output slot, and redirect inputs.
// The fetch controller drives through the master modport; memory and decode sit on the slave modport.
interface pc_fetch_ctrl_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic                     imem_req;
    logic [ADDRESS_WIDTH-1:0] imem_addr;
    logic                     imem_ready;
    logic [ADDRESS_WIDTH-1:0] imem_rdata;
    logic                     instr_valid;
    logic [ADDRESS_WIDTH-1:0] instr;
    logic [ADDRESS_WIDTH-1:0] instr_pc;
    logic                     stall;
    logic                     branch_req;
    logic [ADDRESS_WIDTH-1:0] branch_pc;
    logic [ADDRESS_WIDTH-1:0] branch_imm;
    logic                     fetch_err;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err,
        input  imem_ready, imem_rdata, stall, branch_req, branch_pc, branch_imm
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err,
        output imem_ready, imem_rdata, stall, branch_req, branch_pc, branch_imm
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Single-outstanding fetch sequencer owning the PC; redirect target = branch_pc + (branch_imm << 1).
// Optional REQ watchdog with sticky fetch_err is enabled by defining FETCH_TIMEOUT_EN.
module pc_fetch_ctrl #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
    parameter int                       MAX_WAIT      = 15
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_ctrl_if.master bus
);

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {ST_BOOT, ST_ISSUE, ST_REQ, ST_ERR} state_t;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
`else
    typedef enum logic [1:0] {ST_BOOT, ST_ISSUE, ST_REQ} state_t;
`endif

    state_t                   r_state;
    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic                     r_instr_valid;
    logic [ADDRESS_WIDTH-1:0] r_instr;
    logic [ADDRESS_WIDTH-1:0] r_instr_pc;
    logic                     r_redir_pend;
    logic [ADDRESS_WIDTH-1:0] r_redir_pc;

    logic [ADDRESS_WIDTH-1:0] w_target;
    logic [ADDRESS_WIDTH-1:0] w_redir_tgt;
    logic                     w_redir_any;
    logic                     w_slot_free;
    logic                     w_live;

`ifdef FETCH_TIMEOUT_EN
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_fetch_err;
    logic                     w_wait_last;

    assign w_live      = (r_state != ST_ERR);
    assign w_wait_last = (r_cnt == CNT_W'(MAX_WAIT - 1));
`else
    logic                     w_unused_cfg;

    assign w_live       = 1'b1;
    assign w_unused_cfg = (MAX_WAIT > 0);
`endif

    // A fresh branch_req takes priority over an older pending redirect.
    assign w_target    = bus.branch_pc + (bus.branch_imm << 1);
    assign w_redir_any = bus.branch_req | r_redir_pend;
    assign w_redir_tgt = bus.branch_req ? w_target : r_redir_pc;
    assign w_slot_free = !r_instr_valid || !bus.stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_redir_pend  <= 1'b0;
            r_redir_pc    <= '0;
`ifdef FETCH_TIMEOUT_EN
            r_cnt         <= '0;
            r_fetch_err   <= 1'b0;
`endif
        end else begin
            // Slot consumption and branch flush; the flush overrides stall.
            if (w_live) begin
                if (r_instr_valid && !bus.stall) begin
                    r_instr_valid <= 1'b0;
                end
                if (bus.branch_req) begin
                    r_redir_pc    <= w_target;
                    r_redir_pend  <= 1'b1;
                    r_instr_valid <= 1'b0;
                end
            end

            case (r_state)
                ST_BOOT: begin
                    r_pc    <= RESET_PC;
                    r_state <= ST_ISSUE;
                end

                ST_ISSUE: begin
                    if (w_redir_any) begin
                        r_pc         <= w_redir_tgt;
                        r_redir_pend <= 1'b0;
                        r_state      <= ST_REQ;
                    end else if (w_slot_free) begin
                        r_state <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (bus.imem_ready) begin
                        // A redirect seen during or at the end of the request discards the response.
                        if (w_redir_any) begin
                            r_pc         <= w_redir_tgt;
                            r_redir_pend <= 1'b0;
                        end else begin
                            r_instr       <= bus.imem_rdata;
                            r_instr_pc    <= r_pc;
                            r_instr_valid <= 1'b1;
                            r_pc          <= r_pc + ADDRESS_WIDTH'(4);
                        end
                        r_state <= ST_ISSUE;
`ifdef FETCH_TIMEOUT_EN
                        r_cnt   <= '0;
                    end else if (w_wait_last) begin
                        r_cnt         <= '0;
                        r_fetch_err   <= 1'b1;
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_ERR;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
`endif
                    end
                end

`ifdef FETCH_TIMEOUT_EN
                ST_ERR: begin
                    r_instr_valid <= 1'b0;
                    r_fetch_err   <= 1'b1;
                end
`endif

                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    assign bus.imem_req    = (r_state == ST_REQ);
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
`ifdef FETCH_TIMEOUT_EN
    assign bus.fetch_err   = r_fetch_err;
`else
    assign bus.fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: sequential fetch, stall hold, redirects, wrap, timeout/async reset.
module tb_pc_fetch_ctrl;
    logic clk = 1'b0;
    logic rst;

    pc_fetch_ctrl_if #(.ADDRESS_WIDTH(32)) bus ();

    pc_fetch_ctrl #(
        .ADDRESS_WIDTH(32),
        .RESET_PC     (32'h0),
        .MAX_WAIT     (15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.stall      = 1'b0;
        bus.branch_req = 1'b0;
        bus.branch_pc  = 32'h0;
        bus.branch_imm = 32'h0;
        #2;
        chk_eq("rst_req",   {31'h0, bus.imem_req},    32'h0);
        chk_eq("rst_addr",  bus.imem_addr,            32'h0);
        chk_eq("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk_eq("rst_instr", bus.instr,                32'h0);
        chk_eq("rst_ipc",   bus.instr_pc,             32'h0);
        chk_eq("rst_err",   {31'h0, bus.fetch_err},   32'h0);

        tick(); tick();
        rst = 1'b1;
        tick();
        chk_eq("boot_req", {31'h0, bus.imem_req}, 32'h0);
        tick();
        chk_eq("first_req", {31'h0, bus.imem_req}, 32'h1);

        // Zero-wait memory: one instruction every two cycles.
        bus.imem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_eq($sformatf("seq_addr%0d", k), bus.imem_addr, 32'(4 * k));
            chk_eq($sformatf("seq_req%0d", k), {31'h0, bus.imem_req}, 32'h1);
            chk_eq($sformatf("seq_vld_lo%0d", k), {31'h0, bus.instr_valid}, 32'h0);
            bus.imem_rdata = 32'hA000_0000 | 32'(4 * k);
            tick();
            chk_eq($sformatf("seq_vld%0d", k), {31'h0, bus.instr_valid}, 32'h1);
            chk_eq($sformatf("seq_ipc%0d", k), bus.instr_pc, 32'(4 * k));
            chk_eq($sformatf("seq_instr%0d", k), bus.instr, 32'hA000_0000 | 32'(4 * k));
            chk_eq($sformatf("seq_req_lo%0d", k), {31'h0, bus.imem_req}, 32'h0);
            if (k < 3) tick();
        end

        // Back-pressure holds the slot and blocks issue.
        bus.stall = 1'b1;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk_eq($sformatf("stall_vld%0d", s), {31'h0, bus.instr_valid}, 32'h1);
            chk_eq($sformatf("stall_ipc%0d", s), bus.instr_pc, 32'h0000_000C);
            chk_eq($sformatf("stall_instr%0d", s), bus.instr, 32'hA000_000C);
            chk_eq($sformatf("stall_req%0d", s), {31'h0, bus.imem_req}, 32'h0);
        end
        bus.stall = 1'b0;
        tick();
        chk_eq("unstall_req",  {31'h0, bus.imem_req}, 32'h1);
        chk_eq("unstall_addr", bus.imem_addr, 32'h0000_0010);
        bus.imem_rdata = 32'hA000_0010;
        tick();
        chk_eq("fetch16_vld", {31'h0, bus.instr_valid}, 32'h1);
        chk_eq("fetch16_ipc", bus.instr_pc, 32'h0000_0010);

        // Redirect in ISSUE with a live, stalled instruction.
        bus.stall      = 1'b1;
        bus.branch_req = 1'b1;
        bus.branch_pc  = 32'h0000_0100;
        bus.branch_imm = 32'h0000_0010;
        bus.imem_ready = 1'b0;
        tick();
        bus.branch_req = 1'b0;
        bus.stall      = 1'b0;
        chk_eq("br_issue_addr",  bus.imem_addr, 32'h0000_0120);
        chk_eq("br_issue_req",   {31'h0, bus.imem_req}, 32'h1);
        chk_eq("br_issue_flush", {31'h0, bus.instr_valid}, 32'h0);

        // Redirect in REQ, memory answers after three wait cycles.
        bus.branch_req = 1'b1;
        bus.branch_pc  = 32'h0000_0200;
        bus.branch_imm = 32'h0000_0008;
        tick();
        bus.branch_req = 1'b0;
        for (int w = 0; w < 3; w++) begin
            chk_eq($sformatf("br_req_addr%0d", w), bus.imem_addr, 32'h0000_0120);
            chk_eq($sformatf("br_req_req%0d", w), {31'h0, bus.imem_req}, 32'h1);
            chk_eq($sformatf("br_req_vld%0d", w), {31'h0, bus.instr_valid}, 32'h0);
            if (w < 2) tick();
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk_eq("br_req_discard", {31'h0, bus.instr_valid}, 32'h0);
        chk_eq("br_req_gap",     {31'h0, bus.imem_req}, 32'h0);
        tick();
        chk_eq("br_req_tgt",     bus.imem_addr, 32'h0000_0210);
        chk_eq("br_req_tgt_req", {31'h0, bus.imem_req}, 32'h1);
        bus.imem_rdata = 32'hA000_0210;
        tick();
        chk_eq("tgt_vld",   {31'h0, bus.instr_valid}, 32'h1);
        chk_eq("tgt_ipc",   bus.instr_pc, 32'h0000_0210);
        chk_eq("tgt_instr", bus.instr, 32'hA000_0210);

        // PC wrap through the top of the address space.
        bus.branch_req = 1'b1;
        bus.branch_pc  = 32'hFFFF_FFF0;
        bus.branch_imm = 32'h0000_0006;
        tick();
        bus.branch_req = 1'b0;
        chk_eq("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        chk_eq("wrap_flush", {31'h0, bus.instr_valid}, 32'h0);
        bus.imem_rdata = 32'hA0FF_FFFC;
        tick();
        chk_eq("wrap_ipc", bus.instr_pc, 32'hFFFF_FFFC);
        tick();
        chk_eq("wrap_next", bus.imem_addr, 32'h0000_0000);
        chk_eq("wrap_next_req", {31'h0, bus.imem_req}, 32'h1);
        bus.imem_rdata = 32'hA000_0000;
        tick();
        chk_eq("wrap0_ipc", bus.instr_pc, 32'h0000_0000);
        bus.branch_req = 1'b1;
        bus.branch_pc  = 32'hFFFF_FFF0;
        bus.branch_imm = 32'h0000_0010;
        tick();
        bus.branch_req = 1'b0;
        chk_eq("tgt_wrap", bus.imem_addr, 32'h0000_0010);
        chk_eq("tgt_wrap_req", {31'h0, bus.imem_req}, 32'h1);
        bus.imem_ready = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        for (int c = 0; c < 14; c++) begin
            chk_eq($sformatf("to_err%0d", c), {31'h0, bus.fetch_err}, 32'h0);
            chk_eq($sformatf("to_req%0d", c), {31'h0, bus.imem_req}, 32'h1);
            tick();
        end
        chk_eq("to_last_req", {31'h0, bus.imem_req}, 32'h1);
        chk_eq("to_last_err", {31'h0, bus.fetch_err}, 32'h0);
        tick();
        chk_eq("err_flag", {31'h0, bus.fetch_err}, 32'h1);
        chk_eq("err_req",  {31'h0, bus.imem_req}, 32'h0);
        chk_eq("err_vld",  {31'h0, bus.instr_valid}, 32'h0);
        bus.branch_req = 1'b1;
        bus.stall      = 1'b1;
        bus.imem_ready = 1'b1;
        for (int h = 0; h < 3; h++) begin
            tick();
            chk_eq($sformatf("err_hold_flag%0d", h), {31'h0, bus.fetch_err}, 32'h1);
            chk_eq($sformatf("err_hold_req%0d", h), {31'h0, bus.imem_req}, 32'h0);
        end
        bus.branch_req = 1'b0;
`else
        for (int c = 0; c < 20; c++) tick();
        chk_eq("wait_req",  {31'h0, bus.imem_req}, 32'h1);
        chk_eq("wait_addr", bus.imem_addr, 32'h0000_0010);
        chk_eq("wait_err",  {31'h0, bus.fetch_err}, 32'h0);
`endif

        // Asynchronous reset away from any clock edge.
        #2;
        rst = 1'b0;
        #1;
        chk_eq("arst_req",  {31'h0, bus.imem_req}, 32'h0);
        chk_eq("arst_addr", bus.imem_addr, 32'h0);
        chk_eq("arst_err",  {31'h0, bus.fetch_err}, 32'h0);
        chk_eq("arst_vld",  {31'h0, bus.instr_valid}, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        chk_eq("reboot_req_lo", {31'h0, bus.imem_req}, 32'h0);
        tick();
        chk_eq("reboot_req",  {31'h0, bus.imem_req}, 32'h1);
        chk_eq("reboot_addr", bus.imem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
